sti2stop_lane_buffer: RTL and testbench
=======================================

Name: sti2stop_lane_buffer

Overview:
- Parametrised, multi-lane elastic buffer between the stream-traffic injector (sti) lanes and the stream-operation (stOp) lane inputs of the PE array.
- Each lane has an independent FIFO with valid/ready handshake and a packet framing checker on the lane control field.
- Supports a runtime lane-enable mask and sticky per-lane error flags.
- Generalises the fixed single-width lane connection to N lanes, configurable data/control width and depth.

Parameters:
NUM_LANES, 32, number of independent lanes
DATA_WIDTH, 32, data bits per lane beat
CNTL_WIDTH, 2, control bits per beat (framing code; only the low 2 bits are decoded)
FIFO_DEPTH, 8, entries per lane FIFO (power of 2, >=2)
AFULL_THRESH, 6, occupancy at or above which in_ready drops (1..FIFO_DEPTH)

Ports:
clk  input  1  system clock
reset_poweron  input  1  synchronous active-high reset
lane_en  input  NUM_LANES  per-lane enable mask
in_valid  input  NUM_LANES  sti beat valid, per lane
in_cntl  input  NUM_LANES*CNTL_WIDTH  sti framing code, lane l at [l*CNTL_WIDTH +: CNTL_WIDTH]
in_data  input  NUM_LANES*DATA_WIDTH  sti data, lane l at [l*DATA_WIDTH +: DATA_WIDTH]
in_ready  output  NUM_LANES  buffer can accept, per lane
out_valid  output  NUM_LANES  beat available to stOp
out_cntl  output  NUM_LANES*CNTL_WIDTH  head-of-FIFO framing code
out_data  output  NUM_LANES*DATA_WIDTH  head-of-FIFO data
out_ready  input  NUM_LANES  stOp accepts beat
err_frame  output  NUM_LANES  sticky framing-violation flag
err_ovfl  output  NUM_LANES  sticky overflow flag (valid while not ready)
err_clr  input  NUM_LANES  clears the corresponding sticky flags

Behaviour:
- Reset: all FIFOs empty, pointers and counts 0, framing FSMs IDLE, err_* = 0.
  - in_ready = 0 during reset; after reset it follows the rule below.
  - out_valid = 0; out_cntl and out_data = 0 while empty.
- Reset mid-operation discards all buffered beats; there is no partial drain.
- Framing codes: 2'b00 MOD (middle), 2'b01 SOD (start), 2'b10 EOD (end), 2'b11 SOM (single-beat packet).
- Framing FSM per lane, advanced only on accepted beats:
  - IDLE: SOD goes to IN_PKT; SOM stays IDLE.
  - IDLE: MOD or EOD is a violation.
  - IN_PKT: MOD stays; EOD goes to IDLE.
  - IN_PKT: SOD or SOM is a violation.
- Violation handling: the beat is dropped (not written), err_frame[l] is set, and the FSM is forced to IDLE.
- Accept: a beat is accepted when in_valid & in_ready & lane_en.
  - in_ready[l] = lane_en[l] & (count[l] < AFULL_THRESH), computed only from registered state.
  - in_ready has no combinational path from in_valid or out_ready.
- Overflow: if in_valid[l]=1 while in_ready[l]=0 and lane_en[l]=1 and count[l]==FIFO_DEPTH, then err_ovfl[l] is set and the beat is ignored.
  - in_valid while merely above AFULL_THRESH is legal backpressure, not an error.
- Output is first-word fall-through:
  - out_valid[l] = (count[l] != 0).
  - Head data and cntl are presented the same cycle out_valid rises: write-to-out_valid latency is 1 clk.
  - A pop occurs on out_valid & out_ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - Push into an empty FIFO with out_ready=1: the beat appears the next cycle. No bypass; minimum latency is 1.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Lane disable: lane_en[l] 1->0 flushes that lane on the next edge.
  - count=0, FSM=IDLE, out_valid=0. Error flags are retained.
  - While disabled, in_valid is ignored, with no error.
- err_clr[l] clears the flags on the next edge. If set and clear coincide, set wins.
- Lanes are fully independent; no cross-lane ordering.

Optional Feature:
- Macro LANE_BUFFER_STATS_EN.
- When defined, add per-lane outputs:
  - stat_beats (32b): accepted beats, wraps at 2^32.
  - stat_pkts (16b): completed EOD/SOM packets, wraps.
  - stat_maxocc ($clog2(FIFO_DEPTH)+1 bits): high-water occupancy.
  - All are cleared by reset_poweron or by input stat_clr (1b, global, synchronous).
- When not defined: these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then lane0: SOD,MOD,MOD,EOD with data 0x11..0x14 and out_ready=1.
  - Expect out_valid one cycle after each accept, order and data preserved.
  - Expect count back to 0 and err_frame=0.
- Backpressure with FIFO_DEPTH=8, AFULL_THRESH=6: hold out_ready=0 on lane3 and push continuously.
  - Expect in_ready low once count reaches 6.
  - Expect exactly 6 beats stored, no err_ovfl.
  - Then raise out_ready and expect 6 beats drained in order.
- Framing error: lane5 sends MOD from IDLE, then SOD, SOD.
  - Expect the MOD dropped and err_frame[5] set.
  - Expect the first SOD stored, the second SOD dropped, FSM back in IDLE.
  - Pulse err_clr[5] and expect the flag cleared the next cycle.
- Overflow: force in_valid on lane7 with count=8 (AFULL_THRESH=8).
  - Expect err_ovfl[7]=1 and FIFO contents unchanged.
- Disable mid-packet: lane2 holds 4 beats; drop lane_en[2].
  - Expect out_valid[2]=0 the next cycle, and in_ready[2]=0 while disabled.
  - Re-enable, send SOM 0xAB, and expect it delivered alone with no framing error.
- Concurrent full-rate: all 32 lanes push and pop every cycle with random data.
  - Expect zero loss, per-lane order kept, and count constant at 1 in steady state.
  - With LANE_BUFFER_STATS_EN, expect stat_beats to equal the scoreboard count per lane.

Source files
------------

// File: rtl/sti2stop_lane_buffer.sv
// Multi-lane elastic buffer between sti lanes and stOp lane inputs: per-lane FWFT FIFO with framing checker.
// Optional per-lane statistics counters are enabled by defining LANE_BUFFER_STATS_EN.
module sti2stop_lane_buffer #(
    parameter int NUM_LANES    = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int CNTL_WIDTH   = 2,
    parameter int FIFO_DEPTH   = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic                             clk,
    input  logic                             reset_poweron,
    input  logic [NUM_LANES-1:0]             lane_en,
    input  logic [NUM_LANES-1:0]             in_valid,
    input  logic [NUM_LANES*CNTL_WIDTH-1:0]  in_cntl,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  in_data,
    output logic [NUM_LANES-1:0]             in_ready,
    output logic [NUM_LANES-1:0]             out_valid,
    output logic [NUM_LANES*CNTL_WIDTH-1:0]  out_cntl,
    output logic [NUM_LANES*DATA_WIDTH-1:0]  out_data,
    input  logic [NUM_LANES-1:0]             out_ready,
    output logic [NUM_LANES-1:0]             err_frame,
    output logic [NUM_LANES-1:0]             err_ovfl,
    input  logic [NUM_LANES-1:0]             err_clr
`ifdef LANE_BUFFER_STATS_EN
    ,
    input  logic                                         stat_clr,
    output logic [NUM_LANES*32-1:0]                      stat_beats,
    output logic [NUM_LANES*16-1:0]                      stat_pkts,
    output logic [NUM_LANES*($clog2(FIFO_DEPTH)+1)-1:0]  stat_maxocc
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = CNTL_WIDTH + DATA_WIDTH;

    localparam logic [1:0] CODE_MOD = 2'b00;
    localparam logic [1:0] CODE_SOD = 2'b01;
    localparam logic [1:0] CODE_EOD = 2'b10;
    localparam logic [1:0] CODE_SOM = 2'b11;

    typedef enum logic {
        IDLE,
        IN_PKT
    } frameState_t;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [EW-1:0]          r_mem [FIFO_DEPTH];
        logic [AW-1:0]          r_wrPtr;
        logic [AW-1:0]          r_rdPtr;
        logic [CW-1:0]          r_count;
        frameState_t            r_state;
        frameState_t            w_stateNext;
        logic                   r_errFrame;
        logic                   r_errOvfl;
        logic [CNTL_WIDTH-1:0]  w_cntl;
        logic [1:0]             w_code;
        logic                   w_ready;
        logic                   w_accept;
        logic                   w_viol;
        logic                   w_push;
        logic                   w_pop;
        logic                   w_ovflSet;
        logic                   w_notEmpty;

        assign w_cntl     = in_cntl[l*CNTL_WIDTH +: CNTL_WIDTH];
        assign w_code     = w_cntl[1:0];
        assign w_notEmpty = (r_count != '0);
        // Ready depends only on registered occupancy plus the enable mask and reset.
        assign w_ready    = lane_en[l] & ~reset_poweron & (r_count < CW'(AFULL_THRESH));
        assign w_accept   = in_valid[l] & w_ready;
        assign w_push     = w_accept & ~w_viol;
        assign w_pop      = w_notEmpty & out_ready[l];
        assign w_ovflSet  = in_valid[l] & ~w_ready & lane_en[l] & (r_count == CW'(FIFO_DEPTH));

        always_comb begin
            w_stateNext = r_state;
            w_viol      = 1'b0;
            if (w_accept) begin
                unique case (r_state)
                    IDLE: begin
                        if (w_code == CODE_SOD) begin
                            w_stateNext = IN_PKT;
                        end else if (w_code != CODE_SOM) begin
                            w_viol = 1'b1;
                        end
                    end
                    IN_PKT: begin
                        if (w_code == CODE_EOD) begin
                            w_stateNext = IDLE;
                        end else if (w_code != CODE_MOD) begin
                            w_viol      = 1'b1;
                            w_stateNext = IDLE;
                        end
                    end
                    default: w_stateNext = IDLE;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset_poweron || !lane_en[l]) begin
                r_state <= IDLE;
            end else begin
                r_state <= w_stateNext;
            end
        end

        // Disabling a lane flushes its contents but keeps the sticky flags.
        always_ff @(posedge clk) begin
            if (reset_poweron || !lane_en[l]) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + 1'b1;
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + 1'b1;
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wrPtr] <= {w_cntl, in_data[l*DATA_WIDTH +: DATA_WIDTH]};
            end
        end

        always_ff @(posedge clk) begin
            if (reset_poweron) begin
                r_errFrame <= 1'b0;
                r_errOvfl  <= 1'b0;
            end else begin
                r_errFrame <= w_viol    | (r_errFrame & ~err_clr[l]);
                r_errOvfl  <= w_ovflSet | (r_errOvfl  & ~err_clr[l]);
            end
        end

        assign in_ready[l]  = w_ready;
        assign out_valid[l] = w_notEmpty;
        assign err_frame[l] = r_errFrame;
        assign err_ovfl[l]  = r_errOvfl;
        assign out_cntl[l*CNTL_WIDTH +: CNTL_WIDTH] =
            w_notEmpty ? r_mem[r_rdPtr][EW-1 -: CNTL_WIDTH] : '0;
        assign out_data[l*DATA_WIDTH +: DATA_WIDTH] =
            w_notEmpty ? r_mem[r_rdPtr][DATA_WIDTH-1:0] : '0;

`ifdef LANE_BUFFER_STATS_EN
        logic [31:0]   r_statBeats;
        logic [15:0]   r_statPkts;
        logic [CW-1:0] r_statMaxOcc;

        always_ff @(posedge clk) begin
            if (reset_poweron || stat_clr) begin
                r_statBeats  <= '0;
                r_statPkts   <= '0;
                r_statMaxOcc <= '0;
            end else begin
                r_statBeats <= r_statBeats + 32'(w_push);
                if (w_push && (w_code == CODE_EOD || w_code == CODE_SOM)) begin
                    r_statPkts <= r_statPkts + 16'd1;
                end
                if (r_count > r_statMaxOcc) begin
                    r_statMaxOcc <= r_count;
                end
            end
        end

        assign stat_beats[l*32 +: 32]  = r_statBeats;
        assign stat_pkts[l*16 +: 16]   = r_statPkts;
        assign stat_maxocc[l*CW +: CW] = r_statMaxOcc;
`endif
    end

endmodule

// File: tb/tb_sti2stop_lane_buffer.sv
// Self-checking bench for sti2stop_lane_buffer: queue-based lane model checked every cycle plus directed literals.
// A second small instance with AFULL_THRESH = FIFO_DEPTH exercises the overflow flag.
module tb_sti2stop_lane_buffer;

    localparam int NL  = 32;
    localparam int DW  = 32;
    localparam int CWD = 2;
    localparam int DEP = 8;
    localparam int AF  = 6;
    localparam int NLB = 8;

    localparam logic [1:0] MOD = 2'b00;
    localparam logic [1:0] SOD = 2'b01;
    localparam logic [1:0] EOD = 2'b10;
    localparam logic [1:0] SOM = 2'b11;

    logic              clk = 1'b0;
    logic              rst;
    logic [NL-1:0]     laneEn, inValid, outReady, errClr;
    logic [NL*CWD-1:0] inCntl;
    logic [NL*DW-1:0]  inData;
    logic [NL-1:0]     inReady, outValid, errFrame, errOvfl;
    logic [NL*CWD-1:0] outCntl;
    logic [NL*DW-1:0]  outData;

    logic [NLB-1:0]     bLaneEn, bInValid, bOutReady, bErrClr;
    logic [NLB*CWD-1:0] bInCntl;
    logic [NLB*DW-1:0]  bInData;
    logic [NLB-1:0]     bInReady, bOutValid, bErrFrame, bErrOvfl;
    logic [NLB*CWD-1:0] bOutCntl;
    logic [NLB*DW-1:0]  bOutData;

`ifdef LANE_BUFFER_STATS_EN
    logic              statClr;
    logic [NL*32-1:0]  statBeats;
    logic [NL*16-1:0]  statPkts;
    logic [NL*4-1:0]   statMaxocc;
    logic [NLB*32-1:0] bStatBeats;
    logic [NLB*16-1:0] bStatPkts;
    logic [NLB*4-1:0]  bStatMaxocc;
`endif

    int nChecks = 0;
    int nFails  = 0;
    bit chkEn   = 1'b0;

    logic [33:0] mq [NL][$];
    bit          mInPkt [NL];
    bit          mErrF [NL];
    bit          mErrO [NL];
    int unsigned mBeats [NL];

    sti2stop_lane_buffer #(
        .NUM_LANES(NL), .DATA_WIDTH(DW), .CNTL_WIDTH(CWD), .FIFO_DEPTH(DEP), .AFULL_THRESH(AF)
    ) dutA (
        .clk(clk), .reset_poweron(rst), .lane_en(laneEn), .in_valid(inValid),
        .in_cntl(inCntl), .in_data(inData), .in_ready(inReady), .out_valid(outValid),
        .out_cntl(outCntl), .out_data(outData), .out_ready(outReady),
        .err_frame(errFrame), .err_ovfl(errOvfl), .err_clr(errClr)
`ifdef LANE_BUFFER_STATS_EN
        , .stat_clr(statClr), .stat_beats(statBeats), .stat_pkts(statPkts), .stat_maxocc(statMaxocc)
`endif
    );

    sti2stop_lane_buffer #(
        .NUM_LANES(NLB), .DATA_WIDTH(DW), .CNTL_WIDTH(CWD), .FIFO_DEPTH(DEP), .AFULL_THRESH(DEP)
    ) dutB (
        .clk(clk), .reset_poweron(rst), .lane_en(bLaneEn), .in_valid(bInValid),
        .in_cntl(bInCntl), .in_data(bInData), .in_ready(bInReady), .out_valid(bOutValid),
        .out_cntl(bOutCntl), .out_data(bOutData), .out_ready(bOutReady),
        .err_frame(bErrFrame), .err_ovfl(bErrOvfl), .err_clr(bErrClr)
`ifdef LANE_BUFFER_STATS_EN
        , .stat_clr(statClr), .stat_beats(bStatBeats), .stat_pkts(bStatPkts), .stat_maxocc(bStatMaxocc)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int l, input bit v, input logic [1:0] c, input logic [31:0] d);
        inValid[l]             = v;
        inCntl[l*CWD +: CWD]   = c;
        inData[l*DW +: DW]     = d;
    endtask

    task automatic driveB(input int l, input bit v, input logic [1:0] c, input logic [31:0] d);
        bInValid[l]            = v;
        bInCntl[l*CWD +: CWD]  = c;
        bInData[l*DW +: DW]    = d;
    endtask

    function automatic logic [33:0] beatA(input int l);
        return {outCntl[l*CWD +: CWD], outData[l*DW +: DW]};
    endfunction

    function automatic logic [33:0] beatB(input int l);
        return {bOutCntl[l*CWD +: CWD], bOutData[l*DW +: DW]};
    endfunction

    // Lane model: a queue per lane plus a one-bit "inside packet" flag, updated on every edge.
    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            logic [1:0] code;
            bit rdy, doPop, doPush, setF, setO, legal;
            code   = inCntl[l*CWD +: CWD];
            doPop  = 0;
            doPush = 0;
            setF   = 0;
            setO   = 0;
            if (rst) begin
                mq[l].delete();
                mInPkt[l] = 0;
                mErrF[l]  = 0;
                mErrO[l]  = 0;
                mBeats[l] = 0;
            end else if (!laneEn[l]) begin
                mq[l].delete();
                mInPkt[l] = 0;
                mErrF[l]  = mErrF[l] & ~errClr[l];
                mErrO[l]  = mErrO[l] & ~errClr[l];
            end else begin
                rdy   = mq[l].size() < AF;
                doPop = (mq[l].size() > 0) && outReady[l];
                if (inValid[l] && rdy) begin
                    legal = mInPkt[l] ? (code == MOD || code == EOD) : (code == SOD || code == SOM);
                    if (!legal) begin
                        setF      = 1;
                        mInPkt[l] = 0;
                    end else begin
                        doPush = 1;
                        if (code == SOD) mInPkt[l] = 1;
                        if (code == EOD) mInPkt[l] = 0;
                    end
                end else if (inValid[l] && mq[l].size() == DEP) begin
                    setO = 1;
                end
                if (doPop) void'(mq[l].pop_front());
                if (doPush) begin
                    mq[l].push_back({code, inData[l*DW +: DW]});
                    mBeats[l]++;
                end
                mErrF[l] = setF | (mErrF[l] & ~errClr[l]);
                mErrO[l] = setO | (mErrO[l] & ~errClr[l]);
            end
        end
    end

    always @(negedge clk) begin
        if (chkEn) begin
            logic [NL-1:0] eRdy, eVal, eErrF, eErrO;
            for (int l = 0; l < NL; l++) begin
                eRdy[l]  = !rst && laneEn[l] && (mq[l].size() < AF);
                eVal[l]  = mq[l].size() > 0;
                eErrF[l] = mErrF[l];
                eErrO[l] = mErrO[l];
                checkOutput($sformatf("model_beat_lane%0d", l), 64'(beatA(l)),
                            64'((mq[l].size() > 0) ? mq[l][0] : 34'd0));
            end
            checkOutput("model_in_ready", 64'(inReady), 64'(eRdy));
            checkOutput("model_out_valid", 64'(outValid), 64'(eVal));
            checkOutput("model_err_frame", 64'(errFrame), 64'(eErrF));
            checkOutput("model_err_ovfl", 64'(errOvfl), 64'(eErrO));
        end
    end

    initial begin
        logic [1:0] t1c [4];
        t1c = '{SOD, MOD, MOD, EOD};
        rst = 1'b1;
        laneEn = '1; inValid = '0; outReady = '0; errClr = '0; inCntl = '0; inData = '0;
        bLaneEn = '1; bInValid = '0; bOutReady = '0; bErrClr = '0; bInCntl = '0; bInData = '0;
`ifdef LANE_BUFFER_STATS_EN
        statClr = 1'b0;
`endif
        tick();
        chkEn = 1'b1;
        tick();
        checkOutput("rst_in_ready", 64'(inReady), 64'd0);
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);
        checkOutput("rst_err_frame", 64'(errFrame), 64'd0);
        checkOutput("rst_out_data_lane0", 64'(beatA(0)), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 64'(inReady), 64'hFFFF_FFFF);

        $display("[TB] lane0 packet with out_ready=1");
        outReady[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, t1c[i], 32'h11 + i);
            tick();
            checkOutput("t1_head", 64'(beatA(0)), 64'({t1c[i], 32'h11 + 32'(i)}));
        end
        applyStimulus(0, 0, MOD, 0);
        tick();
        checkOutput("t1_drained", 64'(outValid[0]), 64'd0);
        checkOutput("t1_err_frame", 64'(errFrame[0]), 64'd0);

        $display("[TB] lane3 backpressure");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3, 1, (i == 0) ? SOD : MOD, 32'h300 + i);
            #1;
            checkOutput("t2_in_ready", 64'(inReady[3]), 64'(i < 6));
            tick();
        end
        checkOutput("t2_full_ready", 64'(inReady[3]), 64'd0);
        checkOutput("t2_no_ovfl", 64'(errOvfl[3]), 64'd0);
        applyStimulus(3, 0, MOD, 0);
        outReady[3] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checkOutput("t2_drain", 64'(beatA(3)), 64'({(k == 0) ? SOD : MOD, 32'h300 + 32'(k)}));
            tick();
        end
        checkOutput("t2_empty", 64'(outValid[3]), 64'd0);

        $display("[TB] lane5 framing errors");
        applyStimulus(5, 1, MOD, 32'h51);
        tick();
        checkOutput("t3_mod_err", 64'(errFrame[5]), 64'd1);
        checkOutput("t3_mod_dropped", 64'(outValid[5]), 64'd0);
        applyStimulus(5, 1, SOD, 32'h52);
        tick();
        checkOutput("t3_sod_stored", 64'(beatA(5)), 64'({SOD, 32'h52}));
        applyStimulus(5, 1, SOD, 32'h53);
        tick();
        applyStimulus(5, 0, MOD, 0);
        errClr[5] = 1'b1;
        tick();
        errClr[5] = 1'b0;
        checkOutput("t3_err_cleared", 64'(errFrame[5]), 64'd0);
        applyStimulus(5, 1, SOM, 32'h54);
        tick();
        applyStimulus(5, 0, MOD, 0);
        checkOutput("t3_idle_after_viol", 64'(errFrame[5]), 64'd0);
        outReady[5] = 1'b1;
        checkOutput("t3_head0", 64'(beatA(5)), 64'({SOD, 32'h52}));
        tick();
        checkOutput("t3_head1", 64'(beatA(5)), 64'({SOM, 32'h54}));
        tick();
        checkOutput("t3_empty", 64'(outValid[5]), 64'd0);

        $display("[TB] lane2 disable mid-packet");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2, 1, (i == 0) ? SOD : MOD, 32'h21 + i);
            tick();
        end
        applyStimulus(2, 0, MOD, 0);
        checkOutput("t5_held", 64'(outValid[2]), 64'd1);
        laneEn[2] = 1'b0;
        #1;
        checkOutput("t5_ready_off", 64'(inReady[2]), 64'd0);
        tick();
        checkOutput("t5_flushed", 64'(outValid[2]), 64'd0);
        applyStimulus(2, 1, MOD, 32'h99);
        tick();
        checkOutput("t5_ignored", 64'(outValid[2]), 64'd0);
        checkOutput("t5_no_err", 64'({errFrame[2], errOvfl[2]}), 64'd0);
        laneEn[2] = 1'b1;
        applyStimulus(2, 1, SOM, 32'hAB);
        tick();
        checkOutput("t5_som", 64'(beatA(2)), 64'({SOM, 32'hAB}));
        applyStimulus(2, 0, MOD, 0);
        outReady[2] = 1'b1;
        tick();
        checkOutput("t5_alone", 64'(outValid[2]), 64'd0);
        checkOutput("t5_err_frame", 64'(errFrame[2]), 64'd0);

        $display("[TB] overflow on small instance lane7");
        for (int i = 0; i < 8; i++) begin
            driveB(7, 1, (i == 0) ? SOD : MOD, 32'h70 + i);
            #1;
            if (i == 7) checkOutput("t4_ready_at7", 64'(bInReady[7]), 64'd1);
            tick();
        end
        checkOutput("t4_full_ready", 64'(bInReady[7]), 64'd0);
        checkOutput("t4_no_ovfl_yet", 64'(bErrOvfl[7]), 64'd0);
        driveB(7, 1, MOD, 32'hEE);
        tick();
        checkOutput("t4_ovfl_set", 64'(bErrOvfl[7]), 64'd1);
        driveB(7, 0, MOD, 0);
        bOutReady[7] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checkOutput("t4_contents", 64'(beatB(7)), 64'({(k == 0) ? SOD : MOD, 32'h70 + 32'(k)}));
            tick();
        end
        checkOutput("t4_empty", 64'(bOutValid[7]), 64'd0);
        checkOutput("t4_ovfl_sticky", 64'(bErrOvfl[7]), 64'd1);
        bErrClr[7] = 1'b1;
        tick();
        bErrClr[7] = 1'b0;
        checkOutput("t4_ovfl_cleared", 64'(bErrOvfl[7]), 64'd0);

        $display("[TB] all lanes full rate");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        outReady = '1;
        for (int c = 0; c < 200; c++) begin
            for (int l = 0; l < NL; l++) applyStimulus(l, 1, SOM, $urandom);
            tick();
            checkOutput("t6_steady_valid", 64'(outValid), 64'hFFFF_FFFF);
        end
`ifdef LANE_BUFFER_STATS_EN
        for (int l = 0; l < NL; l++)
            checkOutput("t6_stat_beats", 64'(statBeats[l*32 +: 32]), 64'(mBeats[l]));
`endif

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            for (int l = 0; l < NL; l++) begin
                applyStimulus(l, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), $urandom);
                outReady[l] = $urandom_range(0, 2) == 0;
                laneEn[l]   = $urandom_range(0, 15) != 0;
                errClr[l]   = $urandom_range(0, 7) == 0;
            end
            tick();
        end
`ifdef LANE_BUFFER_STATS_EN
        for (int l = 0; l < NL; l++)
            checkOutput("t7_stat_beats", 64'(statBeats[l*32 +: 32]), 64'(mBeats[l]));
`endif
        inValid = '0;
        tick();
        chkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
